// File: rtl/axi_xbar_1to2_if.sv
// AXI4 channel bundle (AR, R, AW, W, B) shared by the crossbar's upstream
// port and both downstream ports.
//   master modport: drives AR/AW/W payload+valid, rready, bready
//   slave  modport: drives arready/awready/wready, R payload+valid, B payload+valid
interface axi_xbar_1to2_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_xbar_1to2.sv
// One-to-two AXI4 address-decoding crossbar, one transaction outstanding.
// Routes each transaction to m0 (memory/SoC) or m1 (CLINT); unmapped
// addresses are answered internally with DECERR.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   s            upstream AXI4 port (slave modport)
//   m0, m1       downstream AXI4 ports (master modport)
//   perf_*_cnt   transaction counters, present only with XBAR_PERF_EN defined
module axi_xbar_1to2 #(
  parameter logic [31:0] M0_BASE = 32'h8000_0000,
  parameter logic [31:0] M0_SIZE = 32'h0800_0000,
  parameter logic [31:0] M1_BASE = 32'h0200_0000,
  parameter logic [31:0] M1_SIZE = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_xbar_1to2_if.slave        s,
  axi_xbar_1to2_if.master       m0,
  axi_xbar_1to2_if.master       m1
`ifdef XBAR_PERF_EN
  ,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_err_cnt
`endif
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ID_W  = 4;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_M0, RD_M1, RD_ERR, WR_M0, WR_M1, WR_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              addr_done_q, addr_done_d;  // ERR: AR/AW accepted
  logic              w_done_q, w_done_d;        // WR_ERR: wlast accepted
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  err_len_q, err_len_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;

  logic              rd_last_c;   // last R beat handshake upstream
  logic              b_fire_c;    // B handshake upstream

`ifdef XBAR_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d;
  logic [31:0] perf_wr_q, perf_wr_d;
  logic [31:0] perf_err_q, perf_err_d;
`endif

  // Region decode; unsigned wrap makes addresses below base miss.
  function automatic state_e decode(input logic [31:0] addr, input logic is_wr);
    state_e st;
    if ((addr - M0_BASE) < M0_SIZE)      st = is_wr ? WR_M0 : RD_M0;
    else if ((addr - M1_BASE) < M1_SIZE) st = is_wr ? WR_M1 : RD_M1;
    else                                 st = is_wr ? WR_ERR : RD_ERR;
    return st;
  endfunction

  // Transaction-completion events, shared by the FSM and the counters.
  always_comb begin
    rd_last_c = 1'b0;
    b_fire_c  = 1'b0;
    case (state_q)
      RD_M0:  rd_last_c = m0.rvalid & s.rready & m0.rlast;
      RD_M1:  rd_last_c = m1.rvalid & s.rready & m1.rlast;
      RD_ERR: rd_last_c = addr_done_q & s.rready & (beat_cnt_q == err_len_q);
      WR_M0:  b_fire_c  = m0.bvalid & s.bready;
      WR_M1:  b_fire_c  = m1.bvalid & s.bready;
      WR_ERR: b_fire_c  = w_done_q & s.bready;
      default: ;
    endcase
  end

  // Next-state and error-responder bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_done_d = addr_done_q;
    w_done_d    = w_done_q;
    beat_cnt_d  = beat_cnt_q;
    err_len_d   = err_len_q;
    err_id_d    = err_id_q;
    case (state_q)
      IDLE: begin
        if (s.arvalid)      state_d = decode(s.araddr, 1'b0);
        else if (s.awvalid) state_d = decode(s.awaddr, 1'b1);
      end
      RD_M0, RD_M1: if (rd_last_c) state_d = IDLE;
      WR_M0, WR_M1: if (b_fire_c)  state_d = IDLE;
      RD_ERR: begin
        if (!addr_done_q) begin
          if (s.arvalid) begin
            addr_done_d = 1'b1;
            err_id_d    = s.arid;
            err_len_d   = s.arlen;
          end
        end else if (rd_last_c) begin
          state_d = IDLE;
        end else if (s.rready) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
      end
      WR_ERR: begin
        if (!addr_done_q) begin
          if (s.awvalid) begin
            addr_done_d = 1'b1;
            err_id_d    = s.awid;
          end
        end else if (!w_done_q) begin
          if (s.wvalid && s.wlast) w_done_d = 1'b1;
        end else if (b_fire_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every return to IDLE leaves the responder clean for the next decode.
    if (state_d == IDLE) begin
      addr_done_d = 1'b0;
      w_done_d    = 1'b0;
      beat_cnt_d  = '0;
      err_len_d   = '0;
      err_id_d    = '0;
    end
  end

`ifdef XBAR_PERF_EN
  // Wrapping event counters.
  always_comb begin
    perf_rd_d  = perf_rd_q  + 32'(rd_last_c);
    perf_wr_d  = perf_wr_q  + 32'(b_fire_c);
    perf_err_d = perf_err_q + 32'(((state_q == RD_ERR) & rd_last_c) |
                                  ((state_q == WR_ERR) & b_fire_c));
  end

  assign perf_rd_cnt  = perf_rd_q;
  assign perf_wr_cnt  = perf_wr_q;
  assign perf_err_cnt = perf_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_done_q <= 1'b0;
      w_done_q    <= 1'b0;
      beat_cnt_q  <= '0;
      err_len_q   <= '0;
      err_id_q    <= '0;
`ifdef XBAR_PERF_EN
      perf_rd_q   <= '0;
      perf_wr_q   <= '0;
      perf_err_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_done_q <= addr_done_d;
      w_done_q    <= w_done_d;
      beat_cnt_q  <= beat_cnt_d;
      err_len_q   <= err_len_d;
      err_id_q    <= err_id_d;
`ifdef XBAR_PERF_EN
      perf_rd_q   <= perf_rd_d;
      perf_wr_q   <= perf_wr_d;
      perf_err_q  <= perf_err_d;
`endif
    end
  end

  // Channel steering. Everything defaults to zero so IDLE, ERR states and the
  // unselected port never present a valid or ready downstream.
  always_comb begin
    s.arready = 1'b0;
    s.rdata   = '0;  s.rresp = '0;  s.rlast = 1'b0;  s.rid = '0;  s.rvalid = 1'b0;
    s.awready = 1'b0;
    s.wready  = 1'b0;
    s.bresp   = '0;  s.bid   = '0;  s.bvalid = 1'b0;

    m0.araddr = '0;  m0.arid = '0;  m0.arlen = '0;  m0.arsize = '0;  m0.arburst = '0;
    m0.arvalid = 1'b0;  m0.rready = 1'b0;
    m0.awaddr = '0;  m0.awid = '0;  m0.awlen = '0;  m0.awsize = '0;  m0.awburst = '0;
    m0.awvalid = 1'b0;
    m0.wdata  = '0;  m0.wstrb = '0;  m0.wlast = 1'b0;  m0.wvalid = 1'b0;  m0.bready = 1'b0;

    m1.araddr = '0;  m1.arid = '0;  m1.arlen = '0;  m1.arsize = '0;  m1.arburst = '0;
    m1.arvalid = 1'b0;  m1.rready = 1'b0;
    m1.awaddr = '0;  m1.awid = '0;  m1.awlen = '0;  m1.awsize = '0;  m1.awburst = '0;
    m1.awvalid = 1'b0;
    m1.wdata  = '0;  m1.wstrb = '0;  m1.wlast = 1'b0;  m1.wvalid = 1'b0;  m1.bready = 1'b0;

    case (state_q)
      RD_M0: begin
        m0.araddr = s.araddr;  m0.arid = s.arid;  m0.arlen = s.arlen;
        m0.arsize = s.arsize;  m0.arburst = s.arburst;  m0.arvalid = s.arvalid;
        s.arready = m0.arready;
        s.rdata = m0.rdata;  s.rresp = m0.rresp;  s.rlast = m0.rlast;
        s.rid = m0.rid;  s.rvalid = m0.rvalid;  m0.rready = s.rready;
      end
      RD_M1: begin
        m1.araddr = s.araddr;  m1.arid = s.arid;  m1.arlen = s.arlen;
        m1.arsize = s.arsize;  m1.arburst = s.arburst;  m1.arvalid = s.arvalid;
        s.arready = m1.arready;
        s.rdata = m1.rdata;  s.rresp = m1.rresp;  s.rlast = m1.rlast;
        s.rid = m1.rid;  s.rvalid = m1.rvalid;  m1.rready = s.rready;
      end
      WR_M0: begin
        m0.awaddr = s.awaddr;  m0.awid = s.awid;  m0.awlen = s.awlen;
        m0.awsize = s.awsize;  m0.awburst = s.awburst;  m0.awvalid = s.awvalid;
        s.awready = m0.awready;
        m0.wdata = s.wdata;  m0.wstrb = s.wstrb;  m0.wlast = s.wlast;  m0.wvalid = s.wvalid;
        s.wready = m0.wready;
        s.bresp = m0.bresp;  s.bid = m0.bid;  s.bvalid = m0.bvalid;  m0.bready = s.bready;
      end
      WR_M1: begin
        m1.awaddr = s.awaddr;  m1.awid = s.awid;  m1.awlen = s.awlen;
        m1.awsize = s.awsize;  m1.awburst = s.awburst;  m1.awvalid = s.awvalid;
        s.awready = m1.awready;
        m1.wdata = s.wdata;  m1.wstrb = s.wstrb;  m1.wlast = s.wlast;  m1.wvalid = s.wvalid;
        s.wready = m1.wready;
        s.bresp = m1.bresp;  s.bid = m1.bid;  s.bvalid = m1.bvalid;  m1.bready = s.bready;
      end
      RD_ERR: begin
        s.arready = ~addr_done_q;
        s.rvalid  = addr_done_q;
        s.rresp   = addr_done_q ? RESP_DECERR : 2'b00;
        s.rid     = err_id_q;
        s.rlast   = addr_done_q & (beat_cnt_q == err_len_q);
      end
      WR_ERR: begin
        s.awready = ~addr_done_q;
        s.wready  = addr_done_q & ~w_done_q;  // W beats are sunk, not forwarded
        s.bvalid  = w_done_q;
        s.bresp   = w_done_q ? RESP_DECERR : 2'b00;
        s.bid     = err_id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_xbar_1to2.md
Name: axi_xbar_1to2

Overview:
- Address-decoding AXI4 crossbar directly downstream of the IFU/LSU arbiter.
- Takes the single arbitrated master stream and routes each transaction to either the memory/SoC port (m0) or the CLINT port (m1).
- Unmapped addresses get an internally generated DECERR response.
- One transaction outstanding at a time, matching the arbiter's single-transaction model.

Parameters:
- M0_BASE, 32'h8000_0000, memory/SoC region base
- M0_SIZE, 32'h0800_0000, memory/SoC region size in bytes
- M1_BASE, 32'h0200_0000, CLINT region base
- M1_SIZE, 32'h0001_0000, CLINT region size in bytes

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_araddr,s_arid,s_arlen,s_arsize,s_arburst,s_arvalid  in  32,4,8,3,2,1  upstream AR
- s_arready  out  1  upstream AR ready
- s_rdata,s_rresp,s_rlast,s_rid,s_rvalid  out  32,2,1,4,1  upstream R
- s_rready  in  1  upstream R ready
- s_awaddr,s_awid,s_awlen,s_awsize,s_awburst,s_awvalid  in  32,4,8,3,2,1  upstream AW
- s_awready  out  1  upstream AW ready
- s_wdata,s_wstrb,s_wlast,s_wvalid  in  32,4,1,1  upstream W
- s_wready  out  1  upstream W ready
- s_bresp,s_bid,s_bvalid  out  2,4,1  upstream B
- s_bready  in  1  upstream B ready
- mN_* (N=0,1): the same full channel set, directions mirrored (AR/AW/W/rready/bready out; arready/awready/wready/R/B in)

Behaviour:
- Hit rules: region N hit iff (addr - MN_BASE) < MN_SIZE, unsigned 32-bit. Miss on both -> ERR. Regions never overlap.
- States: IDLE, RD_M0, RD_M1, RD_ERR, WR_M0, WR_M1, WR_ERR.
- IDLE: all ready/valid outputs 0. s_arvalid -> decode s_araddr, go to RD_x next cycle. Else s_awvalid -> decode s_awaddr, go to WR_x. Read wins when both valid. Decode latency is 1 cycle.
- RD_M0/RD_M1: full AR and R channels combinationally connected to selected mN; the other port is driven all-zero.
  - Exit to IDLE on s_rvalid & s_rready & s_rlast.
- WR_M0/WR_M1: AW, W and B channels connected to selected port.
  - Exit to IDLE on s_bvalid & s_bready.
- RD_ERR:
  - s_arready=1 until the AR handshake; latch arid and arlen.
  - From the next cycle: s_rvalid=1, s_rdata=0, s_rresp=2'b11, s_rid=latched id.
  - 8-bit beat counter starts at 0 and increments on each R handshake; s_rlast=(cnt==arlen). Exactly arlen+1 beats.
  - IDLE after the last beat.
- WR_ERR:
  - s_awready=1 until the AW handshake; latch awid. Then s_wready=1 and W beats are discarded until wlast handshake.
  - Then s_bvalid=1, s_bresp=2'b11, s_bid=latched id; IDLE on s_bready.
- No neither-port drive: in IDLE and ERR states, mN_arvalid/awvalid/wvalid/rready/bready are all 0.
- Reset (any state, mid-burst included): state=IDLE, counters/latches=0, every output 0 during and after reset. Upstream and downstream are reset together.
- A new decode happens only in IDLE. Address changes while in RD_x/WR_x are not re-decoded.

Optional Feature:
- Macro XBAR_PERF_EN.
- Defined: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0], perf_err_cnt[31:0].
  - rd increments on each completed read transaction (last R handshake); wr on each B handshake.
  - err increments on each ERR-state completion.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Read s_araddr=0x8000_0010 arlen=0; m0 returns rdata=0xDEADBEEF, rresp=0 -> s_rdata=0xDEADBEEF, rlast=1; m1 sees no arvalid; back in IDLE next cycle.
- Write s_awaddr=0x0200_BFF8, wdata=0x1234, wstrb=0xF -> m1 receives AW/W; m1 bresp=0, bid=3 -> s_bid=3, s_bresp=0.
- Read s_araddr=0x1000_0000 arlen=3 arid=5 -> 4 beats of rdata=0, rresp=2'b11, rid=5, rlast only on beat 4; s_rready toggled every other cycle -> counter holds while stalled.
- Write to 0x0000_0000 with awlen=1, two W beats -> both accepted, then bresp=2'b11; no mN valid ever asserted.
- s_arvalid and s_awvalid both high in IDLE (read 0x8000_0000, write 0x8000_0004) -> read completes first; write follows from the next IDLE.
- Assert rst mid RD_ERR beat 2 of 4 -> all outputs 0 immediately. After release, state IDLE and a fresh read to 0x8000_0000 works.
